// File: rtl/vga_ctrl_regbank_if.sv
// vga_ctrl_regbank_if: 68k-side register bus (write/read strobes, address, data, read response).
interface vga_ctrl_regbank_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  modport master (output wr_en, rd_en, addr, wdata, input rdata, rd_valid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rd_valid);
endinterface

// File: rtl/vga_ctrl_regbank.sv
// vga_ctrl_regbank: VGA cursor/control register bank with readback and hardware cursor advance.
// VGAREG_SHADOW_EN adds shadow registers committed to the active set on a vsync rising edge.
module vga_ctrl_regbank #(
  parameter int DATA_W = 8,
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3,
  parameter int MAX_X  = 80,
  parameter int MAX_Y  = 40,
  parameter logic [DATA_W-1:0] CRX_RST = 'h24,
  parameter logic [DATA_W-1:0] CRY_RST = 'h14,
  parameter logic [DATA_W-1:0] CTL_RST = 'hF2
) (
  input  logic                       clk,
  input  logic                       reset_L,
  vga_ctrl_regbank_if.slave          bus,
  input  logic                       vsync,
  input  logic                       cursor_adv,
  output logic [DATA_W-1:0]          crx_out,
  output logic [DATA_W-1:0]          cry_out,
  output logic [DATA_W-1:0]          ctl_out,
  output logic [N_REGS*DATA_W-1:0]   regs_active,
  output logic                       commit_pending
);
  typedef logic [N_REGS-1:0][DATA_W-1:0] bank_t;
  localparam logic [DATA_W-1:0] X_LAST = DATA_W'(MAX_X - 1);
  localparam logic [DATA_W-1:0] Y_LAST = DATA_W'(MAX_Y - 1);
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);
  function automatic bank_t rst_bank();
    bank_t b;
    b    = '0;
    b[0] = CRX_RST;
    b[1] = CRY_RST;
    b[2] = CTL_RST;
    return b;
  endfunction
  localparam bank_t RST_BANK = rst_bank();
  // returns {cry, crx}; any crx at or beyond the last column wraps to 0
  function automatic logic [2*DATA_W-1:0] step_cursor(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return x < X_LAST ? {y, x + ONE} : {(y < Y_LAST ? y + ONE : {DATA_W{1'b0}}), {DATA_W{1'b0}}};
  endfunction
  bank_t             r_act, w_act_b, w_act_n, w_src;
  logic [N_REGS-1:0] w_wsel, w_act_wsel;
  logic [DATA_W-1:0] w_rd_val, r_rdata;
  logic              r_rd_valid, r_pend, w_adv;
  // an advance colliding with a write is parked one cycle; a parked one always drains next cycle
  assign w_adv = r_pend | (cursor_adv & ~bus.wr_en);
  always_comb begin
    w_wsel   = '0;
    w_rd_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      w_wsel[i] = bus.wr_en && bus.addr == ADDR_W'(i);
      if (bus.addr == ADDR_W'(i)) w_rd_val = w_src[i];
    end
  end
  always_comb begin
    w_act_n = w_act_b;
    if (w_adv) {w_act_n[1], w_act_n[0]} = step_cursor(w_act_b[0], w_act_b[1]);
    for (int i = 0; i < N_REGS; i++)
      if (w_act_wsel[i]) w_act_n[i] = bus.wdata;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_act      <= RST_BANK;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_act      <= w_act_n;
      r_rd_valid <= bus.rd_en;
      r_pend     <= cursor_adv & (bus.wr_en | r_pend);
      if (bus.rd_en) r_rdata <= w_rd_val;
    end
  end
`ifdef VGAREG_SHADOW_EN
  bank_t r_sh, w_sh_n;
  logic  r_vs, r_dirty, w_commit;
  assign w_commit       = vsync & ~r_vs & r_dirty;
  assign w_src          = r_sh;
  assign w_act_b        = w_commit ? r_sh : r_act;
  assign w_act_wsel     = '0;
  assign commit_pending = r_dirty;
  always_comb begin
    w_sh_n = r_sh;
    if (w_adv) {w_sh_n[1], w_sh_n[0]} = step_cursor(r_sh[0], r_sh[1]);
    for (int i = 0; i < N_REGS; i++)
      if (w_wsel[i]) w_sh_n[i] = bus.wdata;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_sh    <= RST_BANK;
      r_vs    <= 1'b0;
      r_dirty <= 1'b0;
    end else begin
      r_sh    <= w_sh_n;
      r_vs    <= vsync;
      r_dirty <= |w_wsel | (r_dirty & ~w_commit);
    end
  end
`else
  logic w_unused_vsync;
  assign w_unused_vsync = vsync;
  assign w_src          = r_act;
  assign w_act_b        = r_act;
  assign w_act_wsel     = w_wsel;
  assign commit_pending = 1'b0;
`endif
  assign crx_out      = r_act[0];
  assign cry_out      = r_act[1];
  assign ctl_out      = r_act[2];
  assign regs_active  = r_act;
  assign bus.rdata    = r_rdata;
  assign bus.rd_valid = r_rd_valid;
endmodule
